serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 118 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one shared full-adder cell, one bit per clock, LSB first.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CNT_W-1:0] count;

  logic             fa_sum_c;
  logic             fa_cout_c;
  logic             last_c;

  // Shared full-adder cell operating on the current LSBs and the carry flop
  assign fa_sum_c  = a_sr[0] ^ b_sr[0] ^ carry;
  assign fa_cout_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign last_c    = (count == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_c) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status flags registered from the next state so they line up with the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
    end
  end

  // Operand capture, serial shift datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            count <= '0;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= fa_cout_c;
          sum   <= {fa_sum_c, sum[WIDTH-1:1]};
          count <= count + CNT_W'(1);
          if (last_c) begin
            cout <= fa_cout_c;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random self-checking bench for serial_adder_ctrl (WIDTH=8).
module tb_serial_adder_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 5;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int unsigned n_total;
  int unsigned n_pass;

  serial_adder_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one operation and wait (bounded) for done; lat counts cycles after acceptance
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tc, output int lat);
    a     = ta;
    b     = tb;
    cin   = tc;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = '1;
    b     = '1;
    cin   = 1'b1;
    lat   = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int ndone;
    int t_first;
    int t_second;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    logic [WIDTH:0]   exp9;

    n_total = 0;
    n_pass  = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_sum",  64'(sum),  64'd0);
    check("reset_cout", 64'(cout), 64'd0);

    // 0+0+0: busy rises one cycle after acceptance, done 9 cycles after acceptance
    a = 8'h00; b = 8'h00; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_rise", 64'(busy), 64'd1);
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check("zero_latency", 64'(lat), 64'd9);
    check("zero_busy_in_done", 64'(busy), 64'd1);
    check("zero_sum",  64'(sum),  64'h00);
    check("zero_cout", 64'(cout), 64'd0);
    tick();

    // 0xFF+0x01: single-cycle done pulse, result held 20 idle cycles
    run_op(8'hFF, 8'h01, 1'b0, lat);
    check("ff01_latency", 64'(lat), 64'd9);
    check("ff01_sum",  64'(sum),  64'h00);
    check("ff01_cout", 64'(cout), 64'd1);
    tick();
    check("ff01_done_pulse", 64'(done), 64'd0);
    check("ff01_busy_low",   64'(busy), 64'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) ndone++;
    end
    check("hold_no_done", 64'(ndone), 64'd0);
    check("hold_sum",  64'(sum),  64'h00);
    check("hold_cout", 64'(cout), 64'd1);

    // Carry-in cases
    run_op(8'hA5, 8'h5A, 1'b1, lat);
    check("a55a_sum",  64'(sum),  64'h00);
    check("a55a_cout", 64'(cout), 64'd1);
    tick();
    run_op(8'h3C, 8'h42, 1'b1, lat);
    check("3c42_sum",  64'(sum),  64'h7F);
    check("3c42_cout", 64'(cout), 64'd0);
    tick();

    // Start pulsed 3 cycles into RUN is ignored
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 8'h11; b = 8'h11; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 4;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check("ign_latency", 64'(lat), 64'd9);
    check("ign_sum",  64'(sum),  64'h46);
    check("ign_cout", 64'(cout), 64'd0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) ndone++;
    end
    check("ign_no_second_done", 64'(ndone), 64'd0);
    check("ign_idle", 64'(busy), 64'd0);

    // Reset in the 4th RUN cycle aborts the operation
    a = 8'hF0; b = 8'h0F; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_sum",  64'(sum),  64'h00);
    check("abort_cout", 64'(cout), 64'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    run_op(8'h01, 8'h01, 1'b1, lat);
    check("post_abort_sum",  64'(sum),  64'h03);
    check("post_abort_cout", 64'(cout), 64'd0);
    tick();

    // start held high: back-to-back operations, done pulses 10 cycles apart
    a = 8'h80; b = 8'h81; cin = 1'b0; start = 1'b1;
    t_first  = -1;
    t_second = -1;
    for (int i = 0; i < 40 && t_second < 0; i++) begin
      tick();
      if (done) begin
        check("held_sum",  64'(sum),  64'h01);
        check("held_cout", 64'(cout), 64'd1);
        if (t_first < 0) t_first = i;
        else             t_second = i;
      end
    end
    start = 1'b0;
    check("held_spacing", 64'(t_second - t_first), 64'd10);
    lat = 0;
    while (busy && lat < 40) begin
      tick();
      lat++;
    end
    check("held_drain", 64'(busy), 64'd0);
    tick();

    // Random sweep against a+b+cin
    for (int k = 0; k < 1000; k++) begin
      ra   = WIDTH'($urandom);
      rb   = WIDTH'($urandom);
      rc   = 1'($urandom_range(0, 1));
      exp9 = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
      run_op(ra, rb, rc, lat);
      check("rand_result", 64'({cout, sum}), 64'(exp9));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
